// File: rtl/frame_strobe_writer_pkg.sv
// frame_strobe_writer_pkg: shared FSM state type, default frame geometry and counter sizing
package frame_strobe_writer_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  localparam int DEF_FRAMES   = 20;
  localparam int DEF_ROW_BITS = 32;
  localparam int DEF_SETUP    = 1;
  localparam int DEF_STROBE   = 2;
  localparam int DEF_HOLD     = 1;
  function automatic int cnt_width(input int s, input int st, input int h);
    int m;
    m = (s > st) ? s : st;
    m = (m > h) ? m : h;
    return $clog2(m + 1);
  endfunction
  localparam int CNT_W = cnt_width(DEF_SETUP, DEF_STROBE, DEF_HOLD);
endpackage

// File: rtl/frame_strobe_writer.sv
// frame_strobe_writer: column configuration writer driving FrameData, then one FrameStrobe pulse, then hold
// Ports: UserCLK/reset (sync, active-high); cmd_valid/cmd_ready handshake with cmd_col, cmd_frame, cmd_data;
// FrameData/FrameStrobe to the column; busy (not idle), done (one-cycle completion pulse), err_range (sticky).
// Optional FRAME_STROBE_PARITY_EN adds cmd_parity input and sticky err_parity output.
module frame_strobe_writer
  import frame_strobe_writer_pkg::*;
#(
  parameter int MaxFramesPerCol = DEF_FRAMES,
  parameter int FrameBitsPerRow = DEF_ROW_BITS,
  parameter int ColAddr         = 0,
  parameter int ColBits         = 5,
  parameter int FrameIdxBits    = 5,
  parameter int SetupCycles     = DEF_SETUP,
  parameter int StrobeCycles    = DEF_STROBE,
  parameter int HoldCycles      = DEF_HOLD
) (
  input  logic                       UserCLK,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [ColBits-1:0]         cmd_col,
  input  logic [FrameIdxBits-1:0]    cmd_frame,
  input  logic [FrameBitsPerRow-1:0] cmd_data,
`ifdef FRAME_STROBE_PARITY_EN
  input  logic                       cmd_parity,
  output logic                       err_parity,
`endif
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       done,
  output logic                       err_range
);
  localparam int CW_P = cnt_width(SetupCycles, StrobeCycles, HoldCycles);
  localparam int CW   = (CW_P > CNT_W) ? CW_P : CNT_W;
  state_t                     r_state;
  logic [CW-1:0]              r_cnt;
  logic [FrameIdxBits-1:0]    r_frame;
  logic [FrameBitsPerRow-1:0] r_data;
  logic [MaxFramesPerCol-1:0] r_strobe;
  logic                       r_ready, r_busy, r_done, r_err_range;
  logic                       w_fire, w_match, w_in_range, w_par_ok, w_write, w_zero;
  logic [MaxFramesPerCol-1:0] w_onehot;
  assign w_fire     = cmd_valid && r_ready;
  assign w_match    = cmd_col == ColBits'(ColAddr);
  assign w_in_range = {1'b0, cmd_frame} < (FrameIdxBits + 1)'(MaxFramesPerCol);
`ifdef FRAME_STROBE_PARITY_EN
  logic r_err_parity;
  assign w_par_ok   = (^cmd_data) == cmd_parity;
  assign err_parity = r_err_parity;
`else
  assign w_par_ok   = 1'b1;
`endif
  assign w_write  = w_fire && w_match && w_in_range && w_par_ok;
  assign w_zero   = r_cnt == '0;
  assign w_onehot = MaxFramesPerCol'(1) << r_frame;
  always_ff @(posedge UserCLK) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_frame     <= '0;
      r_data      <= '0;
      r_strobe    <= '0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err_range <= 1'b0;
`ifdef FRAME_STROBE_PARITY_EN
      r_err_parity <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          if (w_write) begin
            r_data  <= cmd_data;
            r_frame <= cmd_frame;
            r_state <= SETUP;
            r_cnt   <= CW'(SetupCycles - 1);
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        SETUP: begin
          r_cnt <= w_zero ? CW'(StrobeCycles - 1) : r_cnt - 1'b1;
          if (w_zero) begin
            r_state  <= STROBE;
            r_strobe <= w_onehot;
          end
        end
        STROBE: begin
          r_cnt <= w_zero ? CW'(HoldCycles - 1) : r_cnt - 1'b1;
          if (w_zero) begin
            r_state  <= HOLD;
            r_strobe <= '0;
          end
        end
        HOLD: begin
          r_cnt <= w_zero ? r_cnt : r_cnt - 1'b1;
          if (w_zero) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_done  <= 1'b1;
          end
        end
      endcase
      if (w_fire && w_match && !w_in_range) r_err_range <= 1'b1;
`ifdef FRAME_STROBE_PARITY_EN
      if (w_fire && w_match && w_in_range && !w_par_ok) r_err_parity <= 1'b1;
`endif
    end
  end
  assign cmd_ready   = r_ready;
  assign FrameData   = r_data;
  assign FrameStrobe = r_strobe;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err_range   = r_err_range;
endmodule

// File: tb/tb_frame_strobe_writer.sv
// tb_frame_strobe_writer: scoreboard bench with directed and random write commands
module tb_frame_strobe_writer;
  localparam int NF = 20, W = 32, SET = 1, STB = 2, HLD = 1;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [4:0] cmd_col = '0, cmd_frame = '0;
  logic [W-1:0] cmd_data = '0;
  logic [W-1:0] FrameData;
  logic [NF-1:0] FrameStrobe;
  logic busy, done, err_range;
`ifdef FRAME_STROBE_PARITY_EN
  logic cmd_parity = 1'b0;
  logic err_parity;
  bit inj_bad_par = 1'b0;
  bit model_perr = 1'b0;
`endif
  always #5 clk = ~clk;
  frame_strobe_writer dut (
    .UserCLK(clk), .reset(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_col(cmd_col), .cmd_frame(cmd_frame), .cmd_data(cmd_data),
`ifdef FRAME_STROBE_PARITY_EN
    .cmd_parity(cmd_parity), .err_parity(err_parity),
`endif
    .FrameData(FrameData), .FrameStrobe(FrameStrobe), .busy(busy), .done(done), .err_range(err_range)
  );
  typedef struct {int acc; int frame; logic [W-1:0] data;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0, cyc = 0;
  bit rst_seen = 1'b1, model_err = 1'b0;
  task automatic chk(input string nm, input bit ok, input string detail);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: %s (cycle %0d)", nm, detail, cyc);
    end
  endtask
  always @(posedge clk) begin
    cyc++;
    rst_seen = rst;
  end
  logic [NF-1:0] prev_strobe = '0;
  int hi_len = 0, pend_done = 0;
  bit pend = 1'b0;
  logic [W-1:0] pend_data = '0;
  always @(negedge clk) begin
    if (rst || rst_seen) begin
      pend = 1'b0;
      hi_len = 0;
      prev_strobe = '0;
    end else begin
      chk("ready_vs_busy", cmd_ready == !busy, $sformatf("ready=%b busy=%b", cmd_ready, busy));
      chk("strobe_onehot", $countones(FrameStrobe) <= 1, $sformatf("got %h", FrameStrobe));
      chk("err_range", err_range == model_err, $sformatf("got %b want %b", err_range, model_err));
`ifdef FRAME_STROBE_PARITY_EN
      chk("err_parity", err_parity == model_perr, $sformatf("got %b want %b", err_parity, model_perr));
`endif
      if (FrameStrobe != '0 && prev_strobe == '0) begin
        if (sb.size() == 0) chk("unexpected_strobe", 1'b0, $sformatf("got %h want 0", FrameStrobe));
        else begin
          exp_t e;
          logic [NF-1:0] es;
          e = sb.pop_front();
          es = '0;
          es[e.frame] = 1'b1;
          chk("strobe_value", FrameStrobe == es, $sformatf("got %h want %h", FrameStrobe, es));
          chk("strobe_data", FrameData == e.data, $sformatf("got %h want %h", FrameData, e.data));
          chk("strobe_rise_cycle", cyc == e.acc + SET, $sformatf("got %0d want %0d", cyc, e.acc + SET));
          pend = 1'b1;
          pend_done = e.acc + SET + STB + HLD;
          pend_data = e.data;
          hi_len = 0;
        end
      end
      if (FrameStrobe != '0) hi_len++;
      if (FrameStrobe == '0 && prev_strobe != '0)
        chk("strobe_width", hi_len == STB, $sformatf("got %0d want %0d", hi_len, STB));
      if (sb.size() > 0 && cyc > sb[0].acc + SET) begin
        chk("missing_strobe", 1'b0, $sformatf("got none want frame %0d", sb[0].frame));
        void'(sb.pop_front());
      end
      if (done) begin
        chk("done_expected", pend, "got done want none");
        if (pend) begin
          chk("done_cycle", cyc == pend_done, $sformatf("got %0d want %0d", cyc, pend_done));
          chk("hold_data", FrameData == pend_data, $sformatf("got %h want %h", FrameData, pend_data));
        end
        pend = 1'b0;
      end else if (pend && cyc > pend_done) begin
        chk("missing_done", 1'b0, $sformatf("got none want cycle %0d", pend_done));
        pend = 1'b0;
      end
      prev_strobe = FrameStrobe;
    end
  end
  task automatic send(input int col, input int frame, input logic [W-1:0] data, input bit hold, output int acc);
    int t;
    bit ok;
    cmd_col = 5'(col);
    cmd_frame = 5'(frame);
    cmd_data = data;
    ok = (col == 0) && (frame < NF);
`ifdef FRAME_STROBE_PARITY_EN
    cmd_parity = (^data) ^ inj_bad_par;
`endif
    cmd_valid = 1'b1;
    t = 0;
    acc = -1;
    while (!cmd_ready && t < 50) begin
      @(posedge clk);
      #1 t++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 1'b0, "got ready=0 want 1 within 50 cycles");
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 acc = cyc;
    if (col == 0 && frame >= NF) model_err = 1'b1;
`ifdef FRAME_STROBE_PARITY_EN
    if (ok && inj_bad_par) begin
      model_perr = 1'b1;
      ok = 1'b0;
    end
`endif
    if (ok) sb.push_back('{acc, frame, data});
    if (!hold) cmd_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    int a1, a2, a3, t;
    idle(2);
    chk("rst_ready", cmd_ready == 1'b0, $sformatf("got %b want 0", cmd_ready));
    chk("rst_data", FrameData == '0, $sformatf("got %h want 0", FrameData));
    chk("rst_strobe_flags", {FrameStrobe, busy, done, err_range} == '0,
        $sformatf("got %h/%b/%b/%b want 0", FrameStrobe, busy, done, err_range));
    rst = 1'b0;
    idle(1);
    chk("ready_after_rst", cmd_ready == 1'b1, $sformatf("got %b want 1", cmd_ready));
    send(0, 3, 32'hA5A5_0F0F, 0, a1);
    chk("data_cycle1", FrameData == 32'hA5A5_0F0F, $sformatf("got %h want a5a50f0f", FrameData));
    idle(6);
    send(7, 4, 32'h1234_5678, 0, a1);
    chk("mismatch_ready", cmd_ready == 1'b1, $sformatf("got %b want 1", cmd_ready));
    idle(5);
    chk("mismatch_data_kept", FrameData == 32'hA5A5_0F0F, $sformatf("got %h want a5a50f0f", FrameData));
    send(0, 25, 32'hDEAD_BEEF, 0, a1);
    idle(5);
    chk("range_sticky", err_range == 1'b1, $sformatf("got %b want 1", err_range));
    send(0, 19, 32'hCAFE_0019, 0, a1);
    idle(6);
    send(0, 1, 32'h0000_0001, 1, a1);
    send(0, 10, 32'h0000_0010, 1, a2);
    send(0, 17, 32'h0000_0017, 0, a3);
    chk("spacing_1_2", a2 - a1 == 5, $sformatf("got %0d want 5", a2 - a1));
    chk("spacing_2_3", a3 - a2 == 5, $sformatf("got %0d want 5", a3 - a2));
    idle(6);
`ifdef FRAME_STROBE_PARITY_EN
    inj_bad_par = 1'b1;
    send(0, 2, 32'h1, 0, a1);
    idle(5);
    inj_bad_par = 1'b0;
    send(0, 2, 32'h1, 0, a1);
    idle(6);
`endif
    send(0, 5, 32'h5555_AAAA, 0, a1);
    t = 0;
    while (FrameStrobe == '0 && t < 10) begin
      @(posedge clk);
      #1 t++;
    end
    chk("strobe_before_abort", FrameStrobe != '0, "got 0 want strobe");
    rst = 1'b1;
    model_err = 1'b0;
`ifdef FRAME_STROBE_PARITY_EN
    model_perr = 1'b0;
`endif
    sb.delete();
    idle(1);
    chk("abort_outputs", {FrameStrobe, FrameData, done, cmd_ready} == '0,
        $sformatf("got %h/%h/%b/%b want 0", FrameStrobe, FrameData, done, cmd_ready));
    rst = 1'b0;
    idle(1);
    chk("abort_ready", cmd_ready == 1'b1, $sformatf("got %b want 1", cmd_ready));
    for (int i = 0; i < 40; i++) begin
      int col, frame;
      bit hold;
      col = ($urandom % 4 == 0) ? int'($urandom_range(1, 31)) : 0;
      frame = ($urandom % 6 == 0) ? int'($urandom_range(20, 31)) : int'($urandom_range(0, 19));
      hold = 1'($urandom % 2);
`ifdef FRAME_STROBE_PARITY_EN
      inj_bad_par = ($urandom % 5 == 0);
`endif
      send(col, frame, $urandom, hold, a1);
      if (!hold) idle(int'($urandom % 3));
    end
    cmd_valid = 1'b0;
    idle(10);
    chk("scoreboard_empty", sb.size() == 0, $sformatf("got %0d pending want 0", sb.size()));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
